// File: rtl/pll_phase_ctrl_pkg.sv
// rtl/pll_phase_ctrl_pkg.sv - shared types, encodings and defaults for the PLL phase stepper
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP
  } state_t;

  // cmd_sel encoding of the EHXPLLL output being shifted
  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam int DEF_SETUP_CYCLES       = 2;
  localparam int DEF_PULSE_CYCLES       = 4;
  localparam int DEF_GAP_CYCLES         = 4;
  localparam int DEF_LOCK_STABLE_CYCLES = 16;
  localparam int DEF_PHASE_WRAP         = 104;

  // One phase step on an 8-bit position, wrapping modulo wrap
  function automatic logic [7:0] wrap_step(input logic [7:0] pos, input logic dir, input int wrap);
    logic [7:0] last;
    last = 8'(wrap - 1);
    if (dir) begin
      wrap_step = (pos == last) ? 8'd0 : pos + 8'd1;
    end else begin
      wrap_step = (pos == 8'd0) ? last : pos - 8'd1;
    end
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock_sync.sv
// rtl/pll_phase_ctrl_lock_sync.sv - PLL lock synchronizer and lock-stable counter
module pll_lock_sync #(
  parameter int LOCK_STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  output logic locked_sync,
  output logic sync_next,
  output logic stable_next
);

  localparam int CW = $clog2(LOCK_STABLE_CYCLES + 1);

  logic          sync1;
  logic [CW-1:0] count;

  // Two-flop synchronizer plus a saturating count of consecutive locked cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      locked_sync <= 1'b0;
      count       <= '0;
    end else begin
      sync1       <= pll_locked;
      locked_sync <= sync1;
      if (!locked_sync) begin
        count <= '0;
      end else if (count != CW'(LOCK_STABLE_CYCLES)) begin
        count <= count + CW'(1);
      end
    end
  end

  // sync_next is the value locked_sync takes next cycle; stable_next flags
  // that the count reaches its target on this edge
  assign sync_next   = sync1;
  assign stable_next = locked_sync && (count >= CW'(LOCK_STABLE_CYCLES - 1));

endmodule

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - EHXPLLL dynamic phase-step sequencer with position tracking
import pll_phase_ctrl_pkg::*;

module pll_phase_ctrl #(
  parameter int SETUP_CYCLES       = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES       = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES         = DEF_GAP_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int PHASE_WRAP         = DEF_PHASE_WRAP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_sel,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_steps,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        locked_sync,
  output logic [31:0] phase_pos,
  output logic [1:0]  pll_phasesel,
  output logic        pll_phasedir,
  output logic        pll_phasestep,
  output logic        pll_phaseloadreg
);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  steps_left, steps_n;
  logic [31:0] pos_n;
  logic [1:0]  sel_n;
  logic        dir_n, done_n, err_n, busy_n, step_n, ready_n;
  logic        sync_next, stable_next;

  pll_lock_sync #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_sync (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .locked_sync(locked_sync),
    .sync_next  (sync_next),
    .stable_next(stable_next)
  );

  // The phase load register is never used; the PLL keeps its configured phase
  assign pll_phaseloadreg = 1'b1;

  // Next-state and next-output logic; lock loss overrides any in-flight step
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    steps_n = steps_left;
    pos_n   = phase_pos;
    sel_n   = pll_phasesel;
    dir_n   = pll_phasedir;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        cnt_n = '0;
        if (stable_next) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_n = '0;
        if (!locked_sync) begin
          state_n = ST_WAIT_LOCK;
        end else if (cmd_valid && cmd_ready) begin
          sel_n   = cmd_sel;
          dir_n   = cmd_dir;
          steps_n = cmd_steps;
          if (cmd_steps == 8'd0) done_n = 1'b1;
          else                   state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == 16'(SETUP_CYCLES - 1)) begin
          state_n = ST_PULSE;
          cnt_n   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt == 16'(PULSE_CYCLES - 1)) begin
          state_n = ST_GAP;
          cnt_n   = '0;
          steps_n = steps_left - 8'd1;
          pos_n[{pll_phasesel, 3'b000} +: 8] =
            wrap_step(phase_pos[{pll_phasesel, 3'b000} +: 8], pll_phasedir, PHASE_WRAP);
        end
      end
      ST_GAP: begin
        if (cnt == 16'(GAP_CYCLES - 1)) begin
          cnt_n = '0;
          if (steps_left == 8'd0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_PULSE;
          end
        end
      end
      default: state_n = ST_WAIT_LOCK;
    endcase
    if ((state == ST_SETUP || state == ST_PULSE || state == ST_GAP) && !locked_sync) begin
      state_n = ST_WAIT_LOCK;
      cnt_n   = '0;
      steps_n = steps_left;
      pos_n   = phase_pos;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
    busy_n  = (state_n == ST_SETUP) || (state_n == ST_PULSE) || (state_n == ST_GAP);
    step_n  = (state_n != ST_PULSE);
    ready_n = (state_n == ST_IDLE) && sync_next;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_WAIT_LOCK;
      cnt           <= '0;
      steps_left    <= '0;
      phase_pos     <= '0;
      pll_phasesel  <= '0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cmd_ready     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      steps_left    <= steps_n;
      phase_pos     <= pos_n;
      pll_phasesel  <= sel_n;
      pll_phasedir  <= dir_n;
      pll_phasestep <= step_n;
      busy          <= busy_n;
      done          <= done_n;
      err           <= err_n;
      cmd_ready     <= ready_n;
    end
  end

endmodule
